// File: rtl/piso_pkg.sv
// Shared types and helpers for the PISO serializer.
// The PARITY state is only reached when PISO_PARITY_EN is defined.
package piso_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// Bit counter for the PISO serializer: cleared on load, counts up on inc.
// tc flags the final data bit (count == WIDTH-1).
module piso_bit_counter #(
    parameter int WIDTH = 8,
    parameter int CW    = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic inc,
    output logic tc
);

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (load) begin
            count <= '0;
        end else if (inc) begin
            count <= count + CW'(1);
        end
    end

    assign tc = (count == CW'(WIDTH - 1));

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out transmitter with valid/ready load and done pulse.
// Define PISO_PARITY_EN to append an even-parity bit after the data bits.
module piso_serializer
    import piso_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             busy,
    output logic             done
);

    localparam int CW = cnt_width(WIDTH);

    state_t           state, state_next;
    logic [WIDTH-1:0] shreg, shreg_next;
    logic             sout_next, valid_next, done_next;
    logic             cnt_load, cnt_inc, tc;
`ifdef PISO_PARITY_EN
    logic             par, par_next;
`endif

    piso_bit_counter #(.WIDTH(WIDTH), .CW(CW)) u_cnt (
        .clk   (clk),
        .reset (reset),
        .load  (cnt_load),
        .inc   (cnt_inc),
        .tc    (tc)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shreg      <= '0;
            sout       <= 1'b0;
            sout_valid <= 1'b0;
            done       <= 1'b0;
`ifdef PISO_PARITY_EN
            par        <= 1'b0;
`endif
        end else begin
            shreg      <= shreg_next;
            sout       <= sout_next;
            sout_valid <= valid_next;
            done       <= done_next;
`ifdef PISO_PARITY_EN
            par        <= par_next;
`endif
        end
    end

    // The bit currently on sout has already been shifted to the top (or bottom)
    // of shreg, so the next bit to present sits one position inward.
    always_comb begin
        state_next = state;
        shreg_next = shreg;
        sout_next  = 1'b0;
        valid_next = 1'b0;
        done_next  = 1'b0;
        cnt_load   = 1'b0;
        cnt_inc    = 1'b0;
`ifdef PISO_PARITY_EN
        par_next   = par;
`endif
        case (state)
            IDLE: begin
                if (load_valid) begin
                    shreg_next = din;
                    sout_next  = (MSB_FIRST != 0) ? din[WIDTH-1] : din[0];
                    valid_next = 1'b1;
                    cnt_load   = 1'b1;
                    state_next = SHIFT;
`ifdef PISO_PARITY_EN
                    par_next   = ^din;
`endif
                end
            end
            SHIFT: begin
                if (!tc) begin
                    cnt_inc    = 1'b1;
                    valid_next = 1'b1;
                    if (MSB_FIRST != 0) begin
                        sout_next  = shreg[WIDTH-2];
                        shreg_next = shreg << 1;
                    end else begin
                        sout_next  = shreg[1];
                        shreg_next = shreg >> 1;
                    end
                end else begin
`ifdef PISO_PARITY_EN
                    sout_next  = par;
                    valid_next = 1'b1;
                    state_next = PARITY;
`else
                    done_next  = 1'b1;
                    state_next = DONE;
`endif
                end
            end
`ifdef PISO_PARITY_EN
            PARITY: begin
                done_next  = 1'b1;
                state_next = DONE;
            end
`endif
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign load_ready = (state == IDLE);
    assign busy       = (state != IDLE);

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: MSB-first and LSB-first instances share stimulus.
// Expected parity bit is checked only when PISO_PARITY_EN is defined.
module tb_piso_serializer;

    typedef struct {
        logic [7:0] din;
        logic [7:0] seq_m;   // expected MSB-first stream, bit 7 sent first
        logic [7:0] seq_l;   // expected LSB-first stream, bit 7 sent first
        logic       par;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] din = '0;
    logic       load_valid = 1'b0;

    logic ready_m, sout_m, valid_m, busy_m, done_m;
    logic ready_l, sout_l, valid_l, busy_l, done_l;

    int checks = 0;
    int errors = 0;
    vec_t vecs[8];

    always #5 clk = ~clk;

    piso_serializer #(.WIDTH(8), .MSB_FIRST(1)) dut_m (
        .clk        (clk),
        .reset      (reset),
        .din        (din),
        .load_valid (load_valid),
        .load_ready (ready_m),
        .sout       (sout_m),
        .sout_valid (valid_m),
        .busy       (busy_m),
        .done       (done_m)
    );

    piso_serializer #(.WIDTH(8), .MSB_FIRST(0)) dut_l (
        .clk        (clk),
        .reset      (reset),
        .din        (din),
        .load_valid (load_valid),
        .load_ready (ready_l),
        .sout       (sout_l),
        .sout_valid (valid_l),
        .busy       (busy_l),
        .done       (done_l)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_ready"}, {ready_m, ready_l}, 2'b11);
        check({tag, "_busy"},  {busy_m, busy_l},   2'b00);
        check({tag, "_valid"}, {valid_m, valid_l}, 2'b00);
        check({tag, "_sout"},  {sout_m, sout_l},   2'b00);
        check({tag, "_done"},  {done_m, done_l},   2'b00);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Entered #1 after the acceptance edge; leaves #1 after the edge that returns to IDLE.
    task automatic stream_check(input vec_t v, input bit scramble);
        for (int i = 0; i < 8; i++) begin
            check("sout_msb", sout_m, v.seq_m[7-i]);
            check("sout_lsb", sout_l, v.seq_l[7-i]);
            check("valid_bit", {valid_m, valid_l}, 2'b11);
            check("busy_bit", {busy_m, busy_l, ready_m, ready_l}, 4'b1100);
            check("done_early", {done_m, done_l}, 2'b00);
            if (scramble) din = 8'($urandom);
            tick();
        end
`ifdef PISO_PARITY_EN
        check("parity_bit", {sout_m, sout_l}, {v.par, v.par});
        check("parity_valid", {valid_m, valid_l, done_m, done_l}, 4'b1100);
        if (scramble) din = 8'($urandom);
        tick();
`endif
        check("done_pulse", {done_m, done_l}, 2'b11);
        check("done_outputs", {valid_m, valid_l, sout_m, sout_l, ready_m, ready_l}, 6'b000000);
        check("done_busy", {busy_m, busy_l}, 2'b11);
        if (scramble) din = 8'($urandom);
        tick();
        check_idle("after_done");
    endtask

    task automatic send_word(input vec_t v);
        int n = 0;
        while (!ready_m && n < 20) begin
            tick();
            n++;
        end
        check("ready_before_load", ready_m, 1'b1);
        din = v.din;
        load_valid = 1'b1;
        tick();
        load_valid = 1'b0;
        din = 8'h5A;
        stream_check(v, 1'b0);
    endtask

    initial begin
        vecs[0] = '{din: 8'hB4, seq_m: 8'hB4, seq_l: 8'h2D, par: 1'b0};
        vecs[1] = '{din: 8'h07, seq_m: 8'h07, seq_l: 8'hE0, par: 1'b1};
        vecs[2] = '{din: 8'hFF, seq_m: 8'hFF, seq_l: 8'hFF, par: 1'b0};
        vecs[3] = '{din: 8'h00, seq_m: 8'h00, seq_l: 8'h00, par: 1'b0};
        vecs[4] = '{din: 8'h01, seq_m: 8'h01, seq_l: 8'h80, par: 1'b1};
        vecs[5] = '{din: 8'hA5, seq_m: 8'hA5, seq_l: 8'hA5, par: 1'b0};
        vecs[6] = '{din: 8'h12, seq_m: 8'h12, seq_l: 8'h48, par: 1'b0};
        vecs[7] = '{din: 8'h80, seq_m: 8'h80, seq_l: 8'h01, par: 1'b1};

        // Reset held for three cycles, then idle with load_valid low.
        repeat (3) tick();
        check_idle("in_reset");
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            din = 8'($urandom);
            tick();
            check_idle("idle_no_load");
        end

        // Table-driven words, one at a time.
        for (int k = 0; k < 8; k++) send_word(vecs[k]);

        // Back-to-back with load_valid held high and din churning during SHIFT.
        din = vecs[0].din;
        load_valid = 1'b1;
        tick();
        stream_check(vecs[0], 1'b1);
        din = vecs[1].din;
        tick();
        stream_check(vecs[1], 1'b0);
        load_valid = 1'b0;

        // Reset mid-word: immediate abort, no done pulse, clean recovery.
        din = vecs[0].din;
        load_valid = 1'b1;
        tick();
        load_valid = 1'b0;
        repeat (3) tick();
        check("pre_abort_valid", {valid_m, valid_l, busy_m, busy_l}, 4'b1111);
        #2 reset = 1'b0;
        #1 check_idle("async_abort");
        for (int i = 0; i < 2; i++) begin
            tick();
            check_idle("abort_hold");
        end
        reset = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            check("no_done_after_abort", {done_m, done_l, busy_m, busy_l}, 4'b0000);
        end
        send_word(vecs[1]);
        send_word(vecs[0]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
